// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter between NREQ burst requesters.
// Latency: request in IDLE -> grant 2 cycles later, first tx_start/pop 3 cycles later; tx_done -> next tx_start 2 cycles.
// Backpressure: no grant while tx_busy_i is high in IDLE; each byte waits for tx_done_i or times out after TIMEOUT cycles.
module uart_tx_sched #(
  parameter int          NREQ       = 4,
  parameter int          MAXLEN     = 8,
  parameter int          GAP_CYCLES = 1250,
  parameter logic [19:0] TIMEOUT    = 20'd1048575
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [NREQ-1:0]        req_i,
  input  logic [4*NREQ-1:0]      len_i,
  input  logic [8*NREQ-1:0]      data_i,
  input  logic [1:0]             baud_req_i,
  input  logic                   tx_busy_i,
  input  logic                   tx_done_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        pop_o,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic [1:0]             baud_sel_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int              IW        = $clog2(NREQ);
  localparam logic [3:0]      MAXLEN_L  = 4'(MAXLEN);
  localparam logic [19:0]     GAP_LAST  = 20'(GAP_CYCLES - 1);
  localparam logic [19:0]     TO_LAST   = TIMEOUT - 20'd1;
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_WAIT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] pop_q, pop_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [1:0]      baud_q, baud_d;
  logic            err_q, err_d;
  logic [3:0]      rem_q, rem_d;
  logic [19:0]     tcnt_q, tcnt_d;
  logic [19:0]     gcnt_q, gcnt_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [3:0]      len_sel;
  logic [3:0]      len_clamp;
  int              cand;

  // Round-robin pick: scan offsets downward so the smallest offset from ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
    len_sel   = len_i[{pick_idx, 2'b00} +: 4];
    len_clamp = (len_sel > MAXLEN_L) ? MAXLEN_L : len_sel;
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    pop_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    baud_d     = baud_q;
    err_d      = 1'b0;
    rem_d      = rem_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = '0;
    case (state_q)
      S_IDLE: begin
        // Baud only tracks the request between bursts.
        baud_d = baud_req_i;
        if ((|req_i) && !tx_busy_i) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_vld) begin
          ptr_d = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
          idx_d = pick_idx;
          rem_d = len_clamp;
          if (len_clamp == 4'd0) begin
            // Zero-length burst: consume the turn, never launch.
            gnt_d   = '0;
            state_d = S_GAP;
          end else begin
            gnt_d   = ONE_HOT0 << pick_idx;
            state_d = S_LOAD;
          end
        end else begin
          // Request vanished between IDLE and ARB.
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        tx_data_d  = data_i[{idx_q, 3'b000} +: 8];
        pop_d      = ONE_HOT0 << idx_q;
        tx_start_d = 1'b1;
        rem_d      = rem_q - 4'd1;
        tcnt_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_i) begin
          if ((rem_q != 4'd0) && req_i[idx_q]) begin
            state_d = S_LOAD;
          end else begin
            gnt_d   = '0;
            state_d = S_GAP;
          end
        end else if (tcnt_q == TO_LAST) begin
          // Transmitter never answered: drop the rest of the burst.
          err_d   = 1'b1;
          gnt_d   = '0;
          state_d = S_GAP;
        end else begin
          tcnt_d = tcnt_q + 20'd1;
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) state_d = S_IDLE;
        else                    gcnt_d  = gcnt_q + 20'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      pop_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      baud_q     <= 2'b11;
      err_q      <= 1'b0;
      rem_q      <= '0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      pop_q      <= pop_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      baud_q     <= baud_d;
      err_q      <= err_d;
      rem_q      <= rem_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign pop_o      = pop_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign baud_sel_o = baud_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
